// File: rtl/override_pkg.sv
// Shared types and constants for the override register bank.
// Channel FSM encoding and release-mode values.
package override_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OVR  = 1'b1
  } state_e;

  localparam logic REL_RETAIN  = 1'b0;
  localparam logic REL_RESTORE = 1'b1;

endpackage

// File: rtl/override_chan.sv
// One channel of the override register bank: value register, override window
// counter, pre-override shadow and the IDLE/OVR control FSM.
module override_chan
  import override_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               CNT_W     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             ovr_start,
  input  logic             ovr_stop,
  input  logic [CNT_W-1:0] ovr_len,
  input  logic             rel_mode,
  input  logic [WIDTH-1:0] ovr_src,
  output logic [WIDTH-1:0] q,
  output logic             ovr_done,
  output logic             wr_drop,
  output state_e           state_o
);

  // All control inputs are single-cycle strobes sampled on the rising edge;
  // there is no backpressure, every strobe is either acted on or reported
  // (wr_drop) in the same edge.
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             rel_q, rel_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;
  logic             expire;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    q_d      = q_q;
    rel_d    = rel_q;
    done_d   = 1'b0;
    drop_d   = 1'b0;
    // cnt stays 0 for an indefinite window, so it never expires by itself
    expire   = (cnt_q == CNT_W'(1));

    case (state_q)
      ST_IDLE: begin
        if (wr_en) begin
          q_d = wr_data;
        end
        if (ovr_start) begin
          state_d  = ST_OVR;
          cnt_d    = ovr_len;
          rel_d    = rel_mode;
          shadow_d = wr_en ? wr_data : q_q;
          q_d      = ovr_src;
        end
      end
      ST_OVR: begin
        drop_d = wr_en;
        // A restart keeps the window open even on its final cycle
        if (ovr_stop || (expire && !ovr_start)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
          if (rel_q == REL_RESTORE) begin
            q_d = shadow_q;
          end
        end else begin
          q_d = ovr_src;
          if (ovr_start) begin
            cnt_d = ovr_len;
            rel_d = rel_mode;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      q_q      <= RESET_VAL;
      rel_q    <= REL_RETAIN;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      q_q      <= q_d;
      rel_q    <= rel_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
    end
  end

  assign q        = q_q;
  assign ovr_done = done_q;
  assign wr_drop  = drop_q;
  assign state_o  = state_q;

endmodule

// File: rtl/override_reg_bank.sv
// Multi-channel register bank with timed override windows; each channel is an
// independent override_chan, this level only slices the packed buses.
module override_reg_bank
  import override_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               CHANNELS  = 4,
  parameter int               CNT_W     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       wr_en,
  input  logic [CHANNELS*WIDTH-1:0] wr_data,
  input  logic [CHANNELS-1:0]       ovr_start,
  input  logic [CHANNELS-1:0]       ovr_stop,
  input  logic [CHANNELS*CNT_W-1:0] ovr_len,
  input  logic [CHANNELS-1:0]       rel_mode,
  input  logic [CHANNELS*WIDTH-1:0] ovr_src,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       ovr_active,
  output logic [CHANNELS-1:0]       ovr_done,
  output logic [CHANNELS-1:0]       wr_drop
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    state_e chan_state;

    override_chan #(
      .WIDTH    (WIDTH),
      .CNT_W    (CNT_W),
      .RESET_VAL(RESET_VAL)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en[i]),
      .wr_data  (wr_data[i*WIDTH +: WIDTH]),
      .ovr_start(ovr_start[i]),
      .ovr_stop (ovr_stop[i]),
      .ovr_len  (ovr_len[i*CNT_W +: CNT_W]),
      .rel_mode (rel_mode[i]),
      .ovr_src  (ovr_src[i*WIDTH +: WIDTH]),
      .q        (q[i*WIDTH +: WIDTH]),
      .ovr_done (ovr_done[i]),
      .wr_drop  (wr_drop[i]),
      .state_o  (chan_state)
    );

    assign ovr_active[i] = (chan_state == ST_OVR);
  end

endmodule
